// File: rtl/dpath_run_ctrl.sv
// Run sequencer for the SPARC datapath: precharge pulse, counted run phase with
// stall/single-step/timeout, finish pulse, then a done flag held until restart.
//
// state | meaning
// IDLE  | waiting for start after reset
// PRE   | precharge pulse, PRE_LEN cycles
// RUN   | datapath advancing; counts advanced cycles
// FIN   | finish pulse, FIN_LEN cycles
// DONE  | run complete, results held until next start
module dpath_run_ctrl #(
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 150,
   parameter int PRE_LEN    = 1,
   parameter int FIN_LEN    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt,
   input  logic             stall,
   input  logic             step_mode,
   input  logic             step,
   output logic             precharge,
   output logic             run_en,
   output logic             finish,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int PH_MAX = (PRE_LEN > FIN_LEN) ? PRE_LEN : FIN_LEN;
   localparam int PC_W   = $clog2(PH_MAX) + 1;
   localparam logic [PC_W-1:0]  PRE_LAST = PC_W'(PRE_LEN - 1);
   localparam logic [PC_W-1:0]  FIN_LAST = PC_W'(FIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_RUN,
      S_FIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             pre_q, fin_q, done_q;
   logic             adv;

   assign adv    = !stall && (!step_mode || step);
   assign run_en = (state_q == S_RUN) && adv;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_PRE;
               pc_d    = '0;
               cnt_d   = '0;
               tmo_d   = 1'b0;
            end
         end
         S_PRE: begin
            if (pc_q == PRE_LAST) begin
               state_d = S_RUN;
               pc_d    = '0;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         S_RUN: begin
            // halt outranks the final increment, so a simultaneous halt is not a timeout
            if (halt) begin
               state_d = S_FIN;
               pc_d    = '0;
            end else if (adv && (cnt_q == CNT_LAST)) begin
               state_d = S_FIN;
               pc_d    = '0;
               cnt_d   = cnt_q + 1'b1;
               tmo_d   = 1'b1;
            end else if (adv) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            if (pc_q == FIN_LAST) begin
               state_d = S_DONE;
               pc_d    = '0;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // Pulse/flag outputs are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
         pre_q   <= 1'b0;
         fin_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         pre_q   <= (state_d == S_PRE);
         fin_q   <= (state_d == S_FIN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign precharge   = pre_q;
   assign finish      = fin_q;
   assign done        = done_q;
   assign timeout     = tmo_q;
   assign cycle_count = cnt_q;

endmodule
